if_fetch_unit: RTL

Instruction fetch unit driving the IF/ID pipeline register. It owns the program counter, issues one-outstanding-request reads to instruction memory over a req/ack handshake, and delivers (pc, instruction, valid) to IF/ID. Decode-side hazard stalls hold fetched instructions in a one-entry buffer. Branch redirects discard wrong-path fetches, including a request already in flight.

---
 rtl/if_fetch_unit_pkg.sv | 14 +
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INST_NOP         = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-outstanding reads, feeds IF/ID,
// buffers one instruction across decode stalls and squashes wrong-path fetches.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        Hz_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        valid_o,
   output logic        stall_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pc_next_q, pc_next_d;
   logic [31:0]  buf_pc_q, buf_pc_d;
   logic [31:0]  buf_inst_q, buf_inst_d;
   logic         buf_vld_q, buf_vld_d;
   logic [31:0]  pc_out_q, pc_out_d;
   logic [31:0]  inst_out_q, inst_out_d;
   logic         valid_q, valid_d;
   // Keeps mem_req_o low while in reset and through the release cycle.
   logic         run_q, run_d;

   logic        ack;
   logic [31:0] target;

   assign target     = branch_target_i & ~32'h3;
   assign mem_req_o  = run_q & (state_q != ST_HOLD);
   assign mem_addr_o = pc_q;
   assign ack        = mem_req_o & mem_ack_i;
   assign stall_o    = mem_req_o & ~mem_ack_i;

   assign pc_o    = pc_out_q;
   assign inst_o  = inst_out_q;
   assign valid_o = valid_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_next_d  = pc_next_q;
      buf_pc_d   = buf_pc_q;
      buf_inst_d = buf_inst_q;
      buf_vld_d  = buf_vld_q;
      pc_out_d   = pc_out_q;
      inst_out_d = inst_out_q;
      valid_d    = 1'b0;
      run_d      = 1'b1;

      unique case (state_q)
         ST_FETCH: begin
            if (branch_i) begin
               // An unacknowledged request cannot be aborted, so park the target.
               if (ack || !mem_req_o) begin
                  pc_d      = target;
                  buf_vld_d = 1'b0;
               end else begin
                  pc_next_d = target;
                  state_d   = ST_DRAIN;
               end
            end else if (ack) begin
               pc_d = pc_q + PC_STEP;
               if (Hz_i) begin
                  buf_pc_d   = pc_q;
                  buf_inst_d = mem_data_i;
                  buf_vld_d  = 1'b1;
                  state_d    = ST_HOLD;
               end else begin
                  pc_out_d   = pc_q;
                  inst_out_d = mem_data_i;
                  valid_d    = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (branch_i) begin
               pc_d      = target;
               buf_vld_d = 1'b0;
               state_d   = ST_FETCH;
            end else if (!Hz_i) begin
               if (buf_vld_q) begin
                  pc_out_d   = buf_pc_q;
                  inst_out_d = buf_inst_q;
                  valid_d    = 1'b1;
               end
               buf_vld_d = 1'b0;
               state_d   = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (ack) begin
               pc_d    = branch_i ? target : pc_next_q;
               state_d = ST_FETCH;
            end else if (branch_i) begin
               pc_next_d = target;
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         pc_next_q  <= RESET_PC;
         buf_pc_q   <= '0;
         buf_inst_q <= INST_NOP;
         buf_vld_q  <= 1'b0;
         pc_out_q   <= '0;
         inst_out_q <= INST_NOP;
         valid_q    <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_next_q  <= pc_next_d;
         buf_pc_q   <= buf_pc_d;
         buf_inst_q <= buf_inst_d;
         buf_vld_q  <= buf_vld_d;
         pc_out_q   <= pc_out_d;
         inst_out_q <= inst_out_d;
         valid_q    <= valid_d;
         run_q      <= run_d;
      end
   end

endmodule
